// File: rtl/vend_controller.sv
// Vending machine controller: credit accumulation, product vend, greedy change return.
// Optional per-slot stock counters are enabled by defining VEND_STOCK_EN.
module vend_controller #(
  parameter int unsigned N_SLOTS    = 9,
  parameter int unsigned MONEY_W    = 10,
  parameter int unsigned MAX_CREDIT = 500,
  localparam int unsigned IDX_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [2:0]         coin_sel,
  input  logic               sel_valid,
  input  logic [IDX_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic               price_we,
  input  logic [IDX_W-1:0]   price_idx,
  input  logic [MONEY_W-1:0] price_wdata,
`ifdef VEND_STOCK_EN
  input  logic               stock_load,
`endif
  output logic [MONEY_W-1:0] credit,
  output logic [N_SLOTS-1:0] avail,
  output logic [N_SLOTS-1:0] oos,
  output logic               vend_valid,
  output logic [IDX_W-1:0]   vend_idx,
  output logic               coin_reject,
  output logic               chg_valid,
  output logic [1:0]         chg_coin,
  input  logic               chg_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t             state;
  logic [MONEY_W-1:0] price [N_SLOTS];
`ifdef VEND_STOCK_EN
  logic [7:0]         stock [N_SLOTS];
`endif

  logic [MONEY_W:0]   coin_amt;
  logic [MONEY_W:0]   coin_sum;
  logic               coin_known;
  logic               coin_fit;
  logic               sel_in_range;
  logic               sel_stocked;
  logic [MONEY_W-1:0] sel_price;
  logic               cancel_take;
  logic               sel_take;
  logic               coin_take;
  logic [MONEY_W-1:0] pay;
  logic [MONEY_W-1:0] rem;

  function automatic logic [1:0] greedy(input logic [MONEY_W-1:0] amt);
    if (amt >= MONEY_W'(100))     return 2'd3;
    else if (amt >= MONEY_W'(25)) return 2'd2;
    else if (amt >= MONEY_W'(10)) return 2'd1;
    else                          return 2'd0;
  endfunction

  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      2'd0:    return MONEY_W'(5);
      2'd1:    return MONEY_W'(10);
      2'd2:    return MONEY_W'(25);
      default: return MONEY_W'(100);
    endcase
  endfunction

  always_comb begin
    coin_known = 1'b1;
    coin_amt   = '0;
    case (coin_sel)
      3'd0:    coin_amt = (MONEY_W+1)'(5);
      3'd1:    coin_amt = (MONEY_W+1)'(10);
      3'd2:    coin_amt = (MONEY_W+1)'(25);
      3'd3:    coin_amt = (MONEY_W+1)'(50);
      3'd4:    coin_amt = (MONEY_W+1)'(100);
      3'd5:    coin_amt = (MONEY_W+1)'(500);
      default: coin_known = 1'b0;
    endcase
    // One extra bit so an over-ceiling sum can never wrap back into range
    coin_sum = {1'b0, credit} + coin_amt;
    coin_fit = (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
`ifdef VEND_STOCK_EN
      oos[i] = (price[i] == '0) || (stock[i] == 8'd0);
`else
      oos[i] = (price[i] == '0);
`endif
      avail[i] = !oos[i] && (credit >= price[i]);
    end
  end

  always_comb begin
    sel_in_range = 1'b0;
    sel_stocked  = 1'b0;
    sel_price    = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_in_range = 1'b1;
        sel_stocked  = !oos[i];
        sel_price    = price[i];
      end
    end
  end

  always_comb begin
    cancel_take = (state == CREDIT) && cancel;
    sel_take    = (state == CREDIT) && !cancel && sel_valid && sel_in_range &&
                  sel_stocked && (sel_price <= credit);
    coin_take   = coin_valid && ((state == IDLE) || (state == CREDIT)) &&
                  !cancel_take && !sel_take && coin_known && coin_fit;
    pay         = coin_value(chg_coin);
    // A sub-5c remainder (odd price) is paid out as one 5c coin and clears credit
    rem         = (credit > pay) ? (credit - pay) : '0;
  end

  assign busy = (state == VEND) || (state == CHANGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        price[i] <= '0;
`ifdef VEND_STOCK_EN
        stock[i] <= 8'd0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
`ifdef VEND_STOCK_EN
        if (price_we && stock_load && (price_idx == IDX_W'(i)))
          stock[i] <= 8'(price_wdata);
        else if (sel_take && (sel_idx == IDX_W'(i)) && (stock[i] != 8'd0))
          stock[i] <= stock[i] - 8'd1;
        if (price_we && !stock_load && (price_idx == IDX_W'(i)))
          price[i] <= price_wdata;
`else
        if (price_we && (price_idx == IDX_W'(i)))
          price[i] <= price_wdata;
`endif
      end
    end
  end

  // Vend pulse and reduced credit are registered on entry so they are visible during VEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      vend_valid  <= 1'b0;
      vend_idx    <= '0;
      coin_reject <= 1'b0;
      chg_valid   <= 1'b0;
      chg_coin    <= '0;
    end else begin
      vend_valid  <= 1'b0;
      coin_reject <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          coin_reject <= coin_valid && !coin_take;
          if (cancel_take) begin
            if (credit != '0) begin
              state     <= CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= greedy(credit);
            end else begin
              state <= IDLE;
            end
          end else if (sel_take) begin
            state      <= VEND;
            credit     <= credit - sel_price;
            vend_valid <= 1'b1;
            vend_idx   <= sel_idx;
          end else if (coin_take) begin
            state  <= CREDIT;
            credit <= coin_sum[MONEY_W-1:0];
          end
        end
        VEND: begin
          coin_reject <= coin_valid;
          if (credit != '0) begin
            state     <= CHANGE;
            chg_valid <= 1'b1;
            chg_coin  <= greedy(credit);
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (chg_valid && chg_ready) begin
            credit <= rem;
            if (rem == '0) begin
              state     <= IDLE;
              chg_valid <= 1'b0;
              chg_coin  <= '0;
            end else begin
              chg_coin <= greedy(rem);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus queues expected reject/vend/change events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vend_controller;
  localparam int unsigned N  = 9;
  localparam int unsigned MW = 10;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin_valid, sel_valid, cancel, price_we, chg_ready;
  logic [2:0]    coin_sel;
  logic [IW-1:0] sel_idx, price_idx, vend_idx;
  logic [MW-1:0] price_wdata, credit;
  logic [N-1:0]  avail, oos;
  logic          vend_valid, coin_reject, chg_valid, busy;
  logic [1:0]    chg_coin;

  vend_controller #(.N_SLOTS(N), .MONEY_W(MW), .MAX_CREDIT(500)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .price_we(price_we), .price_idx(price_idx), .price_wdata(price_wdata),
    .credit(credit), .avail(avail), .oos(oos), .vend_valid(vend_valid),
    .vend_idx(vend_idx), .coin_reject(coin_reject), .chg_valid(chg_valid),
    .chg_coin(chg_coin), .chg_ready(chg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] EV_REJ = 2'd0, EV_VEND = 2'd1, EV_CHG = 2'd2;
  typedef struct packed { logic [1:0] kind; logic [3:0] val; } ev_t;
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [3:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input logic [3:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected event: got kind %0d val %0d expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("event kind/val", {26'd0, k, v}, {26'd0, e.kind, e.val});
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (coin_reject)            observe(EV_REJ, 4'd0);
      if (vend_valid)             observe(EV_VEND, vend_idx);
      if (chg_valid && chg_ready) observe(EV_CHG, {2'b00, chg_coin});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [2:0] s);
    coin_valid = 1'b1; coin_sel = s;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [IW-1:0] idx);
    sel_valid = 1'b1; sel_idx = idx;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic wr_price(input logic [IW-1:0] idx, input logic [MW-1:0] val);
    price_we = 1'b1; price_idx = idx; price_wdata = val;
    step();
    price_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0; coin_sel = '0; sel_valid = 1'b0; sel_idx = '0;
    cancel = 1'b0; price_we = 1'b0; price_idx = '0; price_wdata = '0;
    chg_ready = 1'b1;
    repeat (3) step();
    chk("reset credit", credit, 0);
    chk("reset oos", oos, 32'h1FF);
    chk("reset avail", avail, 0);
    chk("reset busy", busy, 0);
    chk("reset chg_valid", chg_valid, 0);
    rst = 1'b0;
    step();

    // Price write, then vend with 25c change
    wr_price(4'd0, 10'd75);
    chk("oos after price", oos, 32'h1FE);
    chk("avail0 no credit", avail, 0);
    chk("credit idle", credit, 0);
    do_cancel();
    chk("cancel idle ignored", busy, 0);
    coin(3'd3);
    chk("credit 50", credit, 50);
    chk("avail0 at 50", avail, 0);
    coin(3'd3);
    chk("credit 100", credit, 100);
    chk("avail0 at 100", avail, 1);
    expect_ev(EV_VEND, 4'd0);
    expect_ev(EV_CHG, 4'd2);
    select(4'd0);
    chk("credit after vend", credit, 25);
    chk("busy in vend", busy, 1);
    wait_idle("vend change idle");
    chk("credit after change", credit, 0);

    // Ceiling, reject while busy, stalled change
    coin(3'd5);
    chk("credit 500", credit, 500);
    expect_ev(EV_REJ, 4'd0);
    coin(3'd0);
    chk("credit at ceiling", credit, 500);
    chg_ready = 1'b0;
    do_cancel();
    chk("chg_valid on cancel", chg_valid, 1);
    chk("chg_coin 100", chg_coin, 3);
    expect_ev(EV_REJ, 4'd0);
    coin(3'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stall chg_coin", chg_coin, 3);
      chk("stall chg_valid", chg_valid, 1);
      chk("stall credit", credit, 500);
      step();
    end
    repeat (5) expect_ev(EV_CHG, 4'd3);
    chg_ready = 1'b1;
    wait_idle("five 100 idle");
    chk("credit after 500 refund", credit, 0);

    // Ignored selects and invalid coin
    expect_ev(EV_REJ, 4'd0);
    coin(3'd6);
    chk("invalid coin credit", credit, 0);
    select(4'd0);
    chk("select idle ignored", busy, 0);
    coin(3'd2);
    coin(3'd1);
    coin(3'd0);
    chk("credit 40", credit, 40);
    select(4'd0);
    chk("unaffordable credit", credit, 40);
    chk("unaffordable busy", busy, 0);
    select(4'd1);
    chk("oos select credit", credit, 40);
    chk("oos select busy", busy, 0);
    select(4'd12);
    chk("range select busy", busy, 0);
    expect_ev(EV_CHG, 4'd2);
    expect_ev(EV_CHG, 4'd1);
    expect_ev(EV_CHG, 4'd0);
    do_cancel();
    chk("cancel from credit busy", busy, 1);
    wait_idle("refund 40 idle");

    // Cancel beats a same-cycle coin
    coin(3'd2);
    coin(3'd0);
    chk("credit 30", credit, 30);
    expect_ev(EV_REJ, 4'd0);
    expect_ev(EV_CHG, 4'd2);
    expect_ev(EV_CHG, 4'd0);
    cancel = 1'b1; coin_valid = 1'b1; coin_sel = 3'd2;
    step();
    cancel = 1'b0; coin_valid = 1'b0;
    chk("cancel+coin credit", credit, 30);
    wait_idle("refund 30 idle");

    // Reset in the middle of change
    coin(3'd4);
    coin(3'd3);
    chk("credit 150", credit, 150);
    expect_ev(EV_CHG, 4'd3);
    do_cancel();
    chk("first change coin", chg_coin, 3);
    step();
    chk("credit after 1st coin", credit, 50);
    chk("second change coin", chg_coin, 2);
    rst = 1'b1;
    #1;
    chk("mid-change rst credit", credit, 0);
    chk("mid-change rst chg_valid", chg_valid, 0);
    chk("mid-change rst chg_coin", chg_coin, 0);
    chk("mid-change rst busy", busy, 0);
    chk("mid-change rst vend/rej", {30'd0, vend_valid, coin_reject}, 0);
    chk("mid-change rst oos", oos, 32'h1FF);
    chk("mid-change rst avail", avail, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("post reset chg_valid", chg_valid, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameters SHALL be: N_SLOTS, default 9, number of product slots; MONEY_W, default 10, credit/price width in cents; MAX_CREDIT, default 500, credit ceiling in cents.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 coin_valid  input  1  one-cycle coin insert strobe.
REQ-005 coin_sel  input  3  coin/bill value: 0=5, 1=10, 2=25, 3=50, 4=100, 5=500 cents; 6 and 7 are invalid.
REQ-006 sel_valid  input  1  one-cycle product select strobe.
REQ-007 sel_idx  input  $clog2(N_SLOTS)  selected slot.
REQ-008 cancel  input  1  one-cycle cancel/refund strobe.
REQ-009 price_we, price_idx, price_wdata  input  1 / $clog2(N_SLOTS) / MONEY_W  price table write; a price of 0 SHALL mean out of stock.
REQ-010 credit  output  MONEY_W  current credit in cents.
REQ-011 avail, oos  output  N_SLOTS each  green LED per slot (credit >= price and price != 0); red LED per slot (out of stock).
REQ-012 vend_valid, vend_idx  output  1 / $clog2(N_SLOTS)  one-cycle dispense pulse and slot.
REQ-013 coin_reject  output  1  one-cycle pulse when an inserted coin is returned.
REQ-014 chg_valid, chg_coin, chg_ready  out/out/in  1 / 2 / 1  change handshake; chg_coin: 0=5, 1=10, 2=25, 3=100 cents.
REQ-015 busy  output  1  high in VEND and CHANGE states.

Function
REQ-016 The FSM SHALL have four states, IDLE, CREDIT, VEND and CHANGE, and SHALL reset to IDLE.
REQ-017 In IDLE/CREDIT, coin_valid with a valid coin_sel and credit+value <= MAX_CREDIT SHALL add the value to credit on the next cycle and go to CREDIT.
REQ-018 Under the conditions of REQ-017, a coin that would exceed MAX_CREDIT, or an invalid coin_sel, SHALL leave credit unchanged and pulse coin_reject in the next cycle.
REQ-019 The credit comparison SHALL use MONEY_W+1 bits; no wrap-around is permitted.
REQ-020 In CREDIT, sel_valid with a slot that is in stock and price <= credit SHALL go to VEND; in VEND, credit SHALL become credit-price and vend_valid/vend_idx SHALL pulse one cycle.
REQ-021 The cycle after VEND SHALL be CHANGE if credit > 0, otherwise IDLE.
REQ-022 In IDLE, or in CREDIT when the slot is OOS or unaffordable, sel_valid SHALL be ignored; an sel_idx >= N_SLOTS SHALL also be ignored.
REQ-023 cancel in CREDIT SHALL go to CHANGE; cancel in IDLE SHALL be ignored.
REQ-024 CHANGE SHALL dispense greedily, largest coin <= credit (100, 25, 10, 5), with chg_valid held until chg_ready; credit SHALL drop by the coin value on each cycle with chg_valid && chg_ready.
REQ-025 CHANGE SHALL return to IDLE once credit reaches 0; chg_valid and chg_coin SHALL stay stable while chg_ready is low.
REQ-026 While busy, coin_valid SHALL produce coin_reject, and sel_valid and cancel SHALL be ignored.
REQ-027 Precedence in the same cycle SHALL be cancel > sel_valid > coin_valid; the coins of lower-priority events SHALL be rejected.
REQ-028 A price write SHALL take effect on the next cycle in any state; avail and oos SHALL be combinational from registered state.

Reset
REQ-029 On rst, credit SHALL be 0, the state IDLE, all prices 0 (all oos=1, avail=0), and vend_valid, coin_reject, chg_valid, chg_coin and vend_idx 0.
REQ-030 A reset mid-vend or mid-change SHALL abandon the transaction with no further pulses.

Configuration
REQ-031 With VEND_STOCK_EN defined, each slot SHALL have an 8-bit stock counter, loaded via price_we when a stock_load input is high; the counter SHALL decrement on vend and saturate at 0, and oos SHALL be high when price==0 or stock==0.
REQ-032 Without VEND_STOCK_EN, the stock counters and stock_load SHALL be absent, and oos SHALL be high when price==0 only.

Verification
REQ-033 Reset, then write price slot 0 = 75 -> oos[0]=0, avail[0]=0, credit=0.
REQ-034 Insert 50 then 50, select slot 0 -> credit 100, vend_valid with vend_idx=0, then one chg_coin=2 (25), then IDLE with credit 0.
REQ-035 Insert 500, then 5 -> credit 500 and coin_reject pulses; cancel with chg_ready stalled 3 cycles -> chg_coin=3 stays stable; five coins of 100 are dispensed.
REQ-036 Select slot with price 0, or select with credit 40 against price 75 -> no vend and state unchanged.
REQ-037 Same-cycle cancel and coin 25 with credit 30 -> coin rejected, change 25 then 5.
REQ-038 Assert rst during CHANGE after the first coin -> all outputs return to reset values within the same cycle.
